// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction sequencer: coin codes/values,
// state encoding, pricing constants and coin helper functions.
package vend_pkg;

  localparam logic [3:0] COIN_500  = 4'b0001;
  localparam logic [3:0] COIN_1000 = 4'b0010;
  localparam logic [3:0] COIN_2000 = 4'b0100;
  localparam logic [3:0] COIN_5000 = 4'b1000;

  localparam logic [15:0] VAL_500  = 16'd500;
  localparam logic [15:0] VAL_1000 = 16'd1000;
  localparam logic [15:0] VAL_2000 = 16'd2000;
  localparam logic [15:0] VAL_5000 = 16'd5000;

  localparam int PRICE_STEP    = 500;
  localparam int PRODUCT_COUNT = 8;
  localparam int ADDR_W        = $clog2(PRODUCT_COUNT);
  localparam int DISC_NUM      = 9;
  localparam int DISC_SHIFT    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PRICE,
    ST_CHECK,
    ST_DISPENSE,
    ST_CHANGE
  } state_t;

  // Zero for anything that is not exactly one legal one-hot code.
  function automatic logic [15:0] coin_value(input logic [3:0] code);
    case (code)
      COIN_500:  return VAL_500;
      COIN_1000: return VAL_1000;
      COIN_2000: return VAL_2000;
      COIN_5000: return VAL_5000;
      default:   return 16'd0;
    endcase
  endfunction

  function automatic logic [3:0] change_pick(input logic [15:0] amount);
    if (amount >= VAL_2000)      return COIN_2000;
    else if (amount >= VAL_1000) return COIN_1000;
    else if (amount >= VAL_500)  return COIN_500;
    else                         return 4'b0000;
  endfunction

endpackage

// File: rtl/vend_price_calc.sv
// Combinational product price: base step per index, optional 9/16 discount
// rounded up.
module vend_price_calc
  import vend_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              discount_en,
  output logic [15:0]       price
);

  logic [15:0] base;
  logic [31:0] prod;
  logic [31:0] disc;

  always_comb begin
    base = 16'(PRICE_STEP * (int'(addr) + 1));
    prod = 32'(base) * 32'(DISC_NUM);
    disc = (prod >> DISC_SHIFT) + ((prod[DISC_SHIFT-1:0] != '0) ? 32'd1 : 32'd0);
    price = discount_en ? 16'(disc) : base;
  end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit bookkeeping, pricing, funds check and
// dispense/change handshakes.
//
//   state     | meaning
//   IDLE      | credit < 500, accepting coins/selections
//   COLLECT   | credit >= 500, accepting coins/selections, cancel refunds
//   PRICE     | latch effective price of selected product
//   CHECK     | compare credit with price, deduct or refuse
//   DISPENSE  | dispense_valid held until dispense_done
//   CHANGE    | pay out largest coin <= credit until credit < 500
module vend_controller #(
  parameter int MAX_CREDIT     = 20000,
  parameter int DISC_THRESHOLD = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        coin_valid,
  input  logic [3:0]  coin_type,
  input  logic        select_valid,
  input  logic [2:0]  select_addr,
  input  logic        cancel,
  input  logic        dispense_done,
  input  logic        change_ack,
  output logic [15:0] credit,
  output logic [15:0] price,
  output logic [7:0]  sold_count,
  output logic        coin_reject,
  output logic        insufficient,
  output logic        dispense_valid,
  output logic [2:0]  dispense_addr,
  output logic        change_valid,
  output logic [3:0]  change_coin,
  output logic        busy
);
  import vend_pkg::*;

  state_t      state, state_next;
  logic [15:0] credit_next, price_next, calc_price, coin_val;
  logic [16:0] coin_sum;
  logic [7:0]  sold_next;
  logic [2:0]  sel_addr, sel_next, da_next;
  logic        reject_next, insuff_next, dv_next, cv_next, discount_en;
  logic [3:0]  cc_next;

  assign coin_val    = coin_value(coin_type);
  assign coin_sum    = {1'b0, credit} + {1'b0, coin_val};
  assign discount_en = sold_count > 8'(DISC_THRESHOLD);
  assign busy        = (state != ST_IDLE) && (state != ST_COLLECT);

  vend_price_calc u_price_calc (
    .addr        (sel_addr),
    .discount_en (discount_en),
    .price       (calc_price)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      credit         <= '0;
      price          <= '0;
      sold_count     <= '0;
      sel_addr       <= '0;
      coin_reject    <= 1'b0;
      insufficient   <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_addr  <= '0;
      change_valid   <= 1'b0;
      change_coin    <= '0;
    end else begin
      state          <= state_next;
      credit         <= credit_next;
      price          <= price_next;
      sold_count     <= sold_next;
      sel_addr       <= sel_next;
      coin_reject    <= reject_next;
      insufficient   <= insuff_next;
      dispense_valid <= dv_next;
      dispense_addr  <= da_next;
      change_valid   <= cv_next;
      change_coin    <= cc_next;
    end
  end

  always_comb begin
    state_next  = state;
    credit_next = credit;
    price_next  = price;
    sold_next   = sold_count;
    sel_next    = sel_addr;
    reject_next = 1'b0;
    insuff_next = 1'b0;
    dv_next     = dispense_valid;
    da_next     = dispense_addr;
    cv_next     = change_valid;
    cc_next     = change_coin;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (cancel) begin
          reject_next = coin_valid;
          if (state == ST_COLLECT) state_next = ST_CHANGE;
        end else if (coin_valid) begin
          if (coin_val == '0 || coin_sum > 17'(MAX_CREDIT)) begin
            reject_next = 1'b1;
          end else begin
            credit_next = 16'(coin_sum);
            state_next  = (coin_sum >= {1'b0, VAL_500}) ? ST_COLLECT : ST_IDLE;
          end
        end else if (select_valid) begin
          sel_next   = select_addr;
          state_next = ST_PRICE;
        end
      end
      ST_PRICE: begin
        price_next = calc_price;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (credit >= price) begin
          credit_next = credit - price;
          dv_next     = 1'b1;
          da_next     = sel_addr;
          state_next  = ST_DISPENSE;
        end else begin
          insuff_next = 1'b1;
          state_next  = (credit >= VAL_500) ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        if (dispense_valid && dispense_done) begin
          dv_next    = 1'b0;
          sold_next  = (sold_count == 8'hFF) ? sold_count : sold_count + 8'd1;
          state_next = (credit >= VAL_500) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        // Valid drops for a cycle after each ack before the next coin is offered.
        if (change_valid) begin
          if (change_ack) begin
            credit_next = credit - coin_value(change_coin);
            cv_next     = 1'b0;
            cc_next     = '0;
          end
        end else if (credit >= VAL_500) begin
          cv_next = 1'b1;
          cc_next = change_pick(credit);
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (coin_valid && busy) reject_next = 1'b1;
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed and randomized checks of vend_controller against a transaction-level
// credit/sales model.
module tb_vend_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        coin_valid, select_valid, cancel, dispense_done, change_ack;
  logic [3:0]  coin_type;
  logic [2:0]  select_addr;
  logic [15:0] credit, price;
  logic [7:0]  sold_count;
  logic        coin_reject, insufficient, dispense_valid, change_valid, busy;
  logic [2:0]  dispense_addr;
  logic [3:0]  change_coin;

  int compared = 0;
  int failed   = 0;
  int m_credit = 0;
  int m_sold   = 0;

  vend_controller dut (
    .clock          (clock),
    .reset          (reset),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
    .select_valid   (select_valid),
    .select_addr    (select_addr),
    .cancel         (cancel),
    .dispense_done  (dispense_done),
    .change_ack     (change_ack),
    .credit         (credit),
    .price          (price),
    .sold_count     (sold_count),
    .coin_reject    (coin_reject),
    .insufficient   (insufficient),
    .dispense_valid (dispense_valid),
    .dispense_addr  (dispense_addr),
    .change_valid   (change_valid),
    .change_coin    (change_coin),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int face_value(input logic [3:0] code);
    case (code)
      4'b0001: return 500;
      4'b0010: return 1000;
      4'b0100: return 2000;
      4'b1000: return 5000;
      default: return 0;
    endcase
  endfunction

  task automatic insert_coin(input logic [3:0] code);
    int  v;
    bit  ok;
    v  = face_value(code);
    ok = (v != 0) && (m_credit + v <= 20000);
    coin_valid = 1'b1;
    coin_type  = code;
    tick();
    coin_valid = 1'b0;
    if (ok) m_credit += v;
    check("coin_reject", 32'(coin_reject), ok ? 0 : 1);
    check("coin_credit", 32'(credit), m_credit);
    check("coin_busy", 32'(busy), 0);
  endtask

  task automatic drain();
    int         n, v;
    logic [3:0] code;
    while (m_credit >= 500) begin
      n = 0;
      while (!change_valid && n < 8) begin
        tick();
        n++;
      end
      check("chg_wait", 32'(change_valid), 1);
      if (!change_valid) return;
      v    = (m_credit >= 2000) ? 2000 : (m_credit >= 1000) ? 1000 : 500;
      code = (v == 2000) ? 4'b0100 : (v == 1000) ? 4'b0010 : 4'b0001;
      check("chg_coin", 32'(change_coin), 32'(code));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("chg_hold", 32'(change_valid), 1);
      end
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
      m_credit -= v;
      check("chg_drop", 32'(change_valid), 0);
      check("chg_credit", 32'(credit), m_credit);
    end
    tick();
    check("chg_end_idle", 32'(busy), 0);
    check("chg_residual", 32'(credit), m_credit);
  endtask

  task automatic purchase(input logic [2:0] addr, input bit coin_in_dispense);
    int base, exp_price;
    base      = 500 * (int'(addr) + 1);
    exp_price = (m_sold > 10) ? (base * 9 + 15) / 16 : base;
    select_valid = 1'b1;
    select_addr  = addr;
    tick();
    select_valid = 1'b0;
    check("sel_busy", 32'(busy), 1);
    tick();
    check("price", 32'(price), exp_price);
    tick();
    if (m_credit < exp_price) begin
      check("insufficient", 32'(insufficient), 1);
      check("insuf_no_disp", 32'(dispense_valid), 0);
      check("insuf_credit", 32'(credit), m_credit);
      check("insuf_idle", 32'(busy), 0);
      tick();
      check("insuf_pulse_end", 32'(insufficient), 0);
      return;
    end
    m_credit -= exp_price;
    check("disp_valid", 32'(dispense_valid), 1);
    check("disp_addr", 32'(dispense_addr), 32'(addr));
    check("disp_credit", 32'(credit), m_credit);
    if (coin_in_dispense) begin
      coin_valid = 1'b1;
      coin_type  = 4'b0010;
      tick();
      coin_valid = 1'b0;
      check("busy_coin_reject", 32'(coin_reject), 1);
      check("busy_coin_credit", 32'(credit), m_credit);
    end
    repeat ($urandom_range(0, 3)) begin
      tick();
      check("disp_hold", 32'(dispense_valid), 1);
    end
    dispense_done = 1'b1;
    tick();
    dispense_done = 1'b0;
    if (m_sold < 255) m_sold++;
    check("disp_drop", 32'(dispense_valid), 0);
    check("sold_count", 32'(sold_count), m_sold);
    if (m_credit >= 500) drain();
    else check("sale_idle", 32'(busy), 0);
  endtask

  task automatic cancel_op(input bit with_coin);
    cancel = 1'b1;
    if (with_coin) begin
      coin_valid = 1'b1;
      coin_type  = 4'b0001;
    end
    tick();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    if (with_coin) check("cancel_coin_reject", 32'(coin_reject), 1);
    check("cancel_credit", 32'(credit), m_credit);
    if (m_credit >= 500) begin
      check("cancel_busy", 32'(busy), 1);
      drain();
    end else begin
      check("cancel_idle_noop", 32'(busy), 0);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    coin_valid = 1'b0; coin_type = '0; select_valid = 1'b0; select_addr = '0;
    cancel = 1'b0; dispense_done = 1'b0; change_ack = 1'b0;
    repeat (2) tick();
    check("rst_credit", 32'(credit), 0);
    check("rst_price", 32'(price), 0);
    check("rst_sold", 32'(sold_count), 0);
    check("rst_reject", 32'(coin_reject), 0);
    check("rst_insuf", 32'(insufficient), 0);
    check("rst_dv", 32'(dispense_valid), 0);
    check("rst_da", 32'(dispense_addr), 0);
    check("rst_cv", 32'(change_valid), 0);
    check("rst_cc", 32'(change_coin), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();

    // 500 + 1000, buy product 2 at 1500, no change
    insert_coin(4'b0001);
    insert_coin(4'b0010);
    purchase(3'd2, 1'b0);
    check("t1_credit", 32'(credit), 0);

    // 5000 note, buy 500, change 2000/2000/500
    insert_coin(4'b1000);
    purchase(3'd0, 1'b0);

    // insufficient, then cancel refunds 1000
    insert_coin(4'b0010);
    purchase(3'd7, 1'b0);
    cancel_op(1'b0);

    // invalid code, ceiling, coin with cancel, coin while dispensing
    insert_coin(4'b0011);
    repeat (3) insert_coin(4'b1000);
    repeat (2) insert_coin(4'b0100);
    check("t4_19000", 32'(credit), 19000);
    insert_coin(4'b1000);
    cancel_op(1'b1);
    insert_coin(4'b0001);
    purchase(3'd0, 1'b1);

    // reach the discount threshold, then a discounted sale leaves a residual
    while (m_sold < 11) begin
      insert_coin(4'b0001);
      purchase(3'd0, 1'b0);
    end
    insert_coin(4'b0010);
    purchase(3'd0, 1'b0);
    check("t5_residual", 32'(credit), 218);

    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 9);
      if (n <= 4) insert_coin(4'($urandom_range(0, 15)));
      else if (n <= 7) purchase(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else if (n == 8) cancel_op(1'($urandom_range(0, 1)));
      else begin
        tick();
        check("idle_credit", 32'(credit), m_credit);
      end
    end

    // reset while change is being offered
    cancel_op(1'b0);
    insert_coin(4'b0100);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n = 0;
    while (!change_valid && n < 8) begin
      tick();
      n++;
    end
    check("prerst_cv", 32'(change_valid), 1);
    #2 reset = 1'b1;
    #1;
    m_credit = 0;
    m_sold   = 0;
    check("mid_rst_cv", 32'(change_valid), 0);
    check("mid_rst_cc", 32'(change_coin), 0);
    check("mid_rst_credit", 32'(credit), 0);
    check("mid_rst_sold", 32'(sold_count), 0);
    check("mid_rst_price", 32'(price), 0);
    check("mid_rst_busy", 32'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_credit", 32'(credit), m_credit);
    check("post_rst_cv", 32'(change_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the vending machine. It accepts coin/note events, keeps the running credit, looks up and discounts the selected product's price, and checks funds. It then hands off through handshakes to the dispenser and to the change-return hopper. It sits between the money-input front end and the product dispenser, and owns all credit and sale bookkeeping.

## Interface
- MAX_CREDIT, 20000: credit ceiling. A coin that would push credit above this value is rejected.
- DISC_THRESHOLD, 10: discount applies while sold_count > DISC_THRESHOLD.
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high
- coin_valid  in  1  one-cycle coin/note event
- coin_type  in  4  one-hot: 0001=500, 0010=1000, 0100=2000, 1000=5000
- select_valid  in  1  one-cycle product selection
- select_addr  in  3  product index 0..7
- cancel  in  1  one-cycle request to refund all credit
- dispense_done  in  1  dispenser has finished the item
- change_ack  in  1  hopper accepted the current change coin
- credit  out  16  current credit
- price  out  16  effective price of the last selection
- sold_count  out  8  completed sales, saturating at 255
- coin_reject  out  1  one-cycle pulse: coin returned (invalid type, over ceiling, or wrong state)
- insufficient  out  1  one-cycle pulse: selection refused for lack of credit
- dispense_valid  out  1  held high until dispense_done
- dispense_addr  out  3  product to dispense, stable while dispense_valid
- change_valid  out  1  held high until change_ack
- change_coin  out  4  one-hot coin to pay out (2000/1000/500 codes only)
- busy  out  1  high in any state other than IDLE/COLLECT

## Operation
- States: IDLE, COLLECT, PRICE, CHECK, DISPENSE, CHANGE.
- IDLE (credit < 500) and COLLECT (credit ≥ 500): coins and selections are accepted only in these states. Transitions between them follow credit.
- Input priority per cycle is cancel > coin > select. Effects of the lower-priority inputs:
  - a coin present in the same cycle as cancel is rejected;
  - a select present in the same cycle as a coin is dropped.
- Coin handling:
  - A valid coin adds its value to credit.
  - coin_type not one-hot, or credit + value > MAX_CREDIT, gives a coin_reject pulse and leaves credit unchanged.
  - Any coin_valid while busy gives a coin_reject pulse.
- Select: latch select_addr, go to PRICE.
- PRICE:
  - base = 500*(addr+1), i.e. 500..4000.
  - If sold_count > DISC_THRESHOLD, price = ceil(base*9/16), using a 32-bit product, >>4, then +1 if the low 4 bits are nonzero. Otherwise price = base.
  - Go to CHECK.
- CHECK:
  - If credit ≥ price: credit -= price, go to DISPENSE.
  - Otherwise pulse insufficient and return to IDLE/COLLECT with credit unchanged.
- DISPENSE:
  - Raise dispense_valid and wait for dispense_done.
  - On done: sold_count += 1 (saturating at 255). Go to CHANGE if credit ≥ 500, else IDLE.
- Cancel: in COLLECT go to CHANGE. In IDLE, cancel has no effect.
- CHANGE:
  - Pay out the largest coin ≤ credit, from 2000, 1000, 500.
  - Hold change_valid/change_coin until change_ack. On ack, subtract the coin value and re-evaluate.
  - When credit < 500, go to IDLE. The residual (< 500, which can only come from discounted prices) stays in credit for the next transaction.
- Reset mid-transaction: every register returns to its reset value immediately. No dispense or change is completed.

## Timing
- Reset values: state IDLE, and credit, price, sold_count all 0. All pulse and valid outputs are 0; dispense_addr and change_coin are 0.
- Coin: credit is updated on the edge that samples coin_valid and is visible the next cycle. coin_reject is asserted the cycle after the sampled coin.
- Select to decision: select edge, then PRICE (1 cycle), then CHECK (1 cycle). dispense_valid is high two cycles after the select edge. insufficient pulses on the CHECK exit edge.
- dispense_done / change_ack:
  - Sampled only while the corresponding valid is high. Ignored otherwise.
  - Acting on an ack drops the valid for at least one cycle. A change_ack sampled with change_valid high drops change_valid next cycle; the next coin is presented one cycle after that.
- Outputs are registered and have no combinational path from inputs.

## Structure
- Shared package vend_pkg holds:
  - coin one-hot codes and values (500/1000/2000/5000);
  - state encoding;
  - price base step 500 and product count 8;
  - discount numerator 9 and shift 4.
- One sub-module, vend_price_calc: combinational base-price and discount computation (addr, discount_en → price). It is reused by future price displays.

## Test plan
- Insert 500 then 1000 (credit=1500), select addr 2 (price 1500) → dispense_valid with addr 2; after dispense_done, credit=0, IDLE, sold_count=1, no change.
- Credit 5000, select addr 0 → credit 4500 after CHECK. After dispense_done, change coins 2000, 2000, 500, each held until change_ack; final credit 0.
- Credit 1000, select addr 7 (4000) → insufficient pulse, credit stays 1000. Then cancel → one change_coin 1000, IDLE.
- Coin_type 0011, then a 5000 note arriving while credit is 19000 → coin_reject pulse each time, credit unchanged. Also coin_valid during DISPENSE → coin_reject.
- After 11 sales, with credit 1000, select addr 0 → price 282, credit 718 after CHECK. After dispense_done, one 500 coin paid out, residual 218 kept.
- Reset asserted while change_valid is high → all outputs at reset values immediately; next cycle, IDLE with credit 0.
